// File: rtl/tilt_move_encoder.sv
// tilt_move_encoder
//   Turns signed X/Y accelerometer tilt samples into one-cycle movement strobes
//   {right,left,down,up} for the Ball movement input. Each axis averages
//   2**AVG_LOG2 samples. A dead-zone with hysteresis decides the axis direction.
//   Steps are paced slow or fast depending on the tilt magnitude.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        0 suppresses motion; sampling continues
//   sample_valid  sample_x/sample_y valid
//   sample_ready  encoder accepts a sample this cycle
//   sample_x      signed X tilt (+ = right)
//   sample_y      signed Y tilt (+ = down)
//   movement      {right,left,down,up} one-cycle step strobes
//   stale         no sample accepted for STALE_CYC cycles
//
// state  | meaning
// ACCUM  | accepting samples into acc_x/acc_y, sample_ready=1
// UPDATE | one cycle: evaluate averages, move axes, clear accumulators
module tilt_move_encoder #(
  parameter int DATA_W      = 8,
  parameter int AVG_LOG2    = 2,
  parameter int DEADZONE    = 16,
  parameter int HYST        = 4,
  parameter int FAST_THRESH = 64,
  parameter int SLOW_DIV    = 2500000,
  parameter int FAST_DIV    = 500000,
  parameter int STALE_CYC   = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_x,
  input  logic [DATA_W-1:0] sample_y,
  output logic [3:0]        movement,
  output logic              stale
);

  localparam int AW     = DATA_W + AVG_LOG2;
  localparam int EW     = DATA_W + 1;
  localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW     = (MAXDIV > 2) ? $clog2(MAXDIV) : 1;
  localparam int IW     = $clog2(STALE_CYC + 1);

  localparam logic [CW-1:0]        SLOW_TC   = CW'(SLOW_DIV - 1);
  localparam logic [CW-1:0]        FAST_TC   = CW'(FAST_DIV - 1);
  localparam logic [IW-1:0]        STALE_PRE = IW'(STALE_CYC - 1);
  localparam logic [IW-1:0]        STALE_MAX = IW'(STALE_CYC);
  localparam logic signed [EW-1:0] DZ_P      = EW'(DEADZONE);
  localparam logic signed [EW-1:0] DZ_N      = EW'(-DEADZONE);
  localparam logic signed [EW-1:0] REL_P     = EW'(DEADZONE - HYST);
  localparam logic signed [EW-1:0] REL_N     = EW'(HYST - DEADZONE);
  localparam logic signed [EW-1:0] FT        = EW'(FAST_THRESH);

  typedef enum logic {ACCUM, UPDATE} fsm_t;
  typedef enum logic [1:0] {AX_NONE = 2'd0, AX_POS = 2'd1, AX_NEG = 2'd2} axis_t;

  fsm_t                 state;
  logic signed [AW-1:0] acc_x, acc_y;
  logic [AVG_LOG2-1:0]  cnt;
  logic [IW-1:0]        idle;
  axis_t                ax [2];
  logic [CW-1:0]        step [2];
  logic                 fast_cur [2];
  logic                 fast_pend [2];

  logic                 accept, stale_hit;
  logic signed [EW-1:0] avg [2];
  logic signed [EW-1:0] mag [2];
  logic                 fast_new [2];
  axis_t                ax_nxt [2];
  axis_t                ax_d [2];
  logic [CW-1:0]        step_d [2];
  logic                 fc_d [2];
  logic                 fp_d [2];
  logic                 fire [2];
  logic [3:0]           mov_d;

  function automatic axis_t axis_next(input axis_t cur, input logic signed [EW-1:0] a);
    axis_t r;
    r = AX_NONE;
    case (cur)
      AX_POS: begin
        if (a >= REL_P)     r = AX_POS;
        else if (a <= DZ_N) r = AX_NEG;
      end
      AX_NEG: begin
        if (a <= REL_N)     r = AX_NEG;
        else if (a >= DZ_P) r = AX_POS;
      end
      default: begin
        if (a >= DZ_P)      r = AX_POS;
        else if (a <= DZ_N) r = AX_NEG;
      end
    endcase
    return r;
  endfunction

  always_comb begin
    accept    = sample_valid & sample_ready;
    // Fires on the cycle that completes STALE_CYC consecutive idle cycles.
    stale_hit = ~accept & (idle == STALE_PRE);
    avg[0]    = EW'(acc_x >>> AVG_LOG2);
    avg[1]    = EW'(acc_y >>> AVG_LOG2);
    for (int i = 0; i < 2; i++) begin
      // EW = DATA_W+1 so the most negative average still has a positive magnitude.
      mag[i]      = (avg[i] < 0) ? -avg[i] : avg[i];
      fast_new[i] = (mag[i] >= FT);
      ax_nxt[i]   = axis_next(ax[i], avg[i]);
      ax_d[i]     = ax[i];
      step_d[i]   = step[i];
      fc_d[i]     = fast_cur[i];
      fp_d[i]     = fast_pend[i];
      fire[i]     = 1'b0;
      if (!enable || stale_hit) begin
        ax_d[i]   = AX_NONE;
        step_d[i] = '0;
      end else if (state == UPDATE && ax_nxt[i] != ax[i]) begin
        // Entry or reversal strobes immediately; release is silent.
        ax_d[i]   = ax_nxt[i];
        step_d[i] = '0;
        fc_d[i]   = fast_new[i];
        fp_d[i]   = fast_new[i];
        fire[i]   = (ax_nxt[i] != AX_NONE);
      end else if (ax[i] != AX_NONE) begin
        // Same direction: a new period waits in fast_pend until the next wrap.
        if (state == UPDATE) fp_d[i] = fast_new[i];
        if (step[i] == (fast_cur[i] ? FAST_TC : SLOW_TC)) begin
          step_d[i] = '0;
          fire[i]   = 1'b1;
          fc_d[i]   = fp_d[i];
        end else begin
          step_d[i] = step[i] + 1'b1;
        end
      end else begin
        step_d[i] = '0;
      end
    end
    mov_d = {fire[0] & (ax_d[0] == AX_POS), fire[0] & (ax_d[0] == AX_NEG),
             fire[1] & (ax_d[1] == AX_POS), fire[1] & (ax_d[1] == AX_NEG)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ACCUM;
      sample_ready <= 1'b1;
      acc_x        <= '0;
      acc_y        <= '0;
      cnt          <= '0;
      idle         <= '0;
      stale        <= 1'b0;
      movement     <= 4'b0000;
      for (int i = 0; i < 2; i++) begin
        ax[i]        <= AX_NONE;
        step[i]      <= '0;
        fast_cur[i]  <= 1'b0;
        fast_pend[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        idle  <= '0;
        stale <= 1'b0;
      end else if (idle != STALE_MAX) begin
        idle <= idle + 1'b1;
      end
      if (stale_hit) stale <= 1'b1;

      case (state)
        ACCUM: begin
          if (stale_hit) begin
            acc_x <= '0;
            acc_y <= '0;
            cnt   <= '0;
          end else if (accept) begin
            acc_x <= acc_x + AW'($signed(sample_x));
            acc_y <= acc_y + AW'($signed(sample_y));
            cnt   <= cnt + 1'b1;
            if (&cnt) begin
              state        <= UPDATE;
              sample_ready <= 1'b0;
            end
          end
        end
        UPDATE: begin
          acc_x        <= '0;
          acc_y        <= '0;
          cnt          <= '0;
          state        <= ACCUM;
          sample_ready <= 1'b1;
        end
      endcase

      movement <= mov_d;
      for (int i = 0; i < 2; i++) begin
        ax[i]        <= ax_d[i];
        step[i]      <= step_d[i];
        fast_cur[i]  <= fc_d[i];
        fast_pend[i] <= fp_d[i];
      end
    end
  end

endmodule

// File: tb/tb_tilt_move_encoder.sv
module tb_tilt_move_encoder;

  localparam int SLOW  = 20;
  localparam int FAST  = 8;
  localparam int STALE = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       sample_valid = 1'b0;
  logic       sample_ready;
  logic [7:0] sample_x = 8'd0;
  logic [7:0] sample_y = 8'd0;
  logic [3:0] movement;
  logic       stale;

  int checks = 0;
  int errors = 0;

  tilt_move_encoder #(
    .DATA_W(8), .AVG_LOG2(2), .DEADZONE(16), .HYST(4), .FAST_THRESH(64),
    .SLOW_DIV(SLOW), .FAST_DIV(FAST), .STALE_CYC(STALE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sample_x), .sample_y(sample_y),
    .movement(movement), .stale(stale)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model (timestamp based) ----------------
  bit       m_ready = 1'b1;
  bit       m_upd = 1'b0;
  bit       m_stale = 1'b0;
  logic [3:0] m_mov = 4'b0000;
  int       idle_n = 0;
  int       t = 0;
  int       dir [2] = '{0, 0};
  int       per [2] = '{SLOW, SLOW};
  int       nxt [2] = '{0, 0};
  int       qx [$];
  int       qy [$];

  function automatic int fdiv4(input int s);
    int q;
    q = s / 4;
    if ((s % 4 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int decide(input int cur, input int a);
    if (cur == 1 && a >= 12) return 1;
    if (cur == -1 && a <= -12) return -1;
    if (a >= 16) return 1;
    if (a <= -16) return -1;
    return 0;
  endfunction

  function automatic int period_of(input int a);
    int m;
    m = (a < 0) ? -a : a;
    return (m >= 64) ? FAST : SLOW;
  endfunction

  task automatic model_reset();
    m_ready = 1'b1; m_upd = 1'b0; m_stale = 1'b0; m_mov = 4'b0000; idle_n = 0;
    qx.delete(); qy.delete();
    for (int a = 0; a < 2; a++) begin dir[a] = 0; per[a] = SLOW; nxt[a] = 0; end
  endtask

  task automatic model_step();
    bit acc, was_upd, stale_evt;
    int avg [2];
    int nd [2];
    int np [2];
    int sx, sy, b;
    if (!reset_n) begin model_reset(); return; end
    t++;
    acc = sample_valid && m_ready;
    was_upd = m_upd;
    stale_evt = 1'b0;
    if (acc) begin
      idle_n = 0; m_stale = 1'b0;
    end else begin
      idle_n++;
      if (idle_n == STALE) begin
        stale_evt = 1'b1; m_stale = 1'b1; qx.delete(); qy.delete();
      end
    end
    nd = '{0, 0}; np = '{SLOW, SLOW};
    if (was_upd) begin
      sx = 0; sy = 0;
      foreach (qx[k]) sx += qx[k];
      foreach (qy[k]) sy += qy[k];
      avg[0] = fdiv4(sx); avg[1] = fdiv4(sy);
      for (int a = 0; a < 2; a++) begin
        nd[a] = decide(dir[a], avg[a]);
        np[a] = period_of(avg[a]);
      end
      qx.delete(); qy.delete();
      m_upd = 1'b0; m_ready = 1'b1;
    end else if (acc) begin
      qx.push_back(int'($signed(sample_x)));
      qy.push_back(int'($signed(sample_y)));
      if (qx.size() == 4) begin m_upd = 1'b1; m_ready = 1'b0; end
    end
    m_mov = 4'b0000;
    for (int a = 0; a < 2; a++) begin
      b = -1;
      if (!enable || stale_evt) begin
        dir[a] = 0;
      end else if (was_upd && nd[a] != dir[a]) begin
        dir[a] = nd[a]; per[a] = np[a];
        if (dir[a] != 0) begin b = (a == 0) ? 2 : 0; nxt[a] = t + per[a]; end
      end else if (dir[a] != 0) begin
        if (was_upd) per[a] = np[a];
        if (t == nxt[a]) begin b = (a == 0) ? 2 : 0; nxt[a] = t + per[a]; end
      end
      if (b >= 0) m_mov[b + ((dir[a] > 0) ? 1 : 0)] = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- compare process + strobe log ----------------
  bit chk_en = 1'b0;
  int ncyc = 0;
  int tr [$];
  int tl [$];
  int td [$];
  int tu [$];

  initial forever begin
    @(negedge clk);
    ncyc++;
    if (chk_en) begin
      checks++;
      if ({movement, stale, sample_ready} !== {m_mov, m_stale, m_ready}) begin
        errors++;
        if (errors < 25)
          $display("FAIL cycle %0d: got mov=%b stale=%b rdy=%b, model mov=%b stale=%b rdy=%b",
                   ncyc, movement, stale, sample_ready, m_mov, m_stale, m_ready);
      end
    end
    if (movement[3] === 1'b1) tr.push_back(ncyc);
    if (movement[2] === 1'b1) tl.push_back(ncyc);
    if (movement[1] === 1'b1) td.push_back(ncyc);
    if (movement[0] === 1'b1) tu.push_back(ncyc);
  end

  // ---------------- helpers ----------------
  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic gap(input string nm, input int q[$], input int i, input int j, input int exp);
    checks++;
    if (q.size() <= j) begin
      errors++;
      $display("FAIL %s: only %0d strobes seen, need %0d", nm, q.size(), j + 1);
    end else if (q[j] - q[i] != exp) begin
      errors++;
      $display("FAIL %s: gap %0d expected %0d", nm, q[j] - q[i], exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int x, input int y);
    bit r;
    int g;
    g = 0;
    sample_valid = 1'b1;
    sample_x = 8'(x);
    sample_y = 8'(y);
    do begin
      r = sample_ready;
      tick();
      g++;
    end while (!r && g < 10);
    if (!r) begin
      errors++;
      $display("FAIL send_timeout: sample_ready stayed %0b for %0d cycles", sample_ready, g);
    end
    sample_valid = 1'b0;
  endtask

  task automatic batch(input int x, input int y, input int n);
    repeat (n) send(x, y);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic clearq();
    tr.delete(); tl.delete(); td.delete(); tu.delete();
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int n0, burst, dis_cnt, tx, ty;
  int tgt [16] = '{-128, -70, -64, -63, -20, -16, -15, -12, 0, 12, 13, 16, 40, 64, 100, 127};

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    lit("rst_movement", movement, 4'b0000);
    lit("rst_stale", stale, 1'b0);
    lit("rst_ready", sample_ready, 1'b1);
    reset_n = 1'b1;
    tick();

    // slow right strobes, repeating every SLOW cycles
    clearq();
    batch(32, 0, 4);
    tick();
    lit("s1_first", movement, 4'b1000);
    repeat (42) tick();
    gap("s1_gap1", tr, 0, 1, 20);
    gap("s1_gap2", tr, 1, 2, 20);
    lit("s1_low_bits", tl.size() + td.size() + tu.size(), 0);

    // fast then slower tilt: period change applies at the next wrap
    do_reset();
    clearq();
    batch(100, 0, 4);
    tick();
    lit("s2_first", movement, 4'b1000);
    batch(40, 0, 4);
    repeat (50) tick();
    gap("s2_gap_fast", tr, 0, 1, 8);
    gap("s2_gap_slow1", tr, 1, 2, 20);
    gap("s2_gap_slow2", tr, 2, 3, 20);

    // hysteresis: 14 holds, 10 releases
    do_reset();
    clearq();
    batch(32, 0, 4);
    batch(14, 0, 4);
    repeat (25) tick();
    lit("s3_hold", tr.size(), 2);
    batch(10, 0, 4);
    repeat (45) tick();
    lit("s3_release", tr.size(), 2);

    // both axes negative, then reversal of X
    do_reset();
    clearq();
    batch(-128, -20, 4);
    tick();
    lit("s4_first", movement, 4'b0101);
    repeat (41) tick();
    gap("s4_left_gap", tl, 0, 1, 8);
    gap("s4_up_gap", tu, 0, 1, 20);
    gap("s4_coincide", tl, 0, 5, 40);
    gap("s4_up_40", tu, 0, 2, 40);
    batch(32, 0, 4);
    tick();
    lit("s4_reverse", movement, 4'b1000);

    // stale after STALE idle cycles (the UPDATE cycle counts as idle)
    repeat (98) tick();
    lit("s5_not_yet", stale, 1'b0);
    tick();
    lit("s5_stale", stale, 1'b1);
    lit("s5_stale_mov", movement, 4'b0000);
    n0 = tr.size();
    send(32, 0);
    lit("s5_clear", stale, 1'b0);
    batch(32, 0, 3);
    lit("s5_quiet", tr.size() - n0, 0);
    tick();
    lit("s5_resume", movement, 4'b1000);

    // reset mid-accumulation, then enable gating
    do_reset();
    batch(32, 0, 4);
    tick();
    batch(32, 0, 2);
    reset_n = 1'b0;
    tick();
    lit("s6_rst_mov", movement, 4'b0000);
    lit("s6_rst_stale", stale, 1'b0);
    lit("s6_rst_ready", sample_ready, 1'b1);
    reset_n = 1'b1;
    tick();
    clearq();
    batch(32, 0, 2);
    lit("s6_no_update", sample_ready, 1'b1);
    enable = 1'b0;
    batch(32, 0, 6);
    repeat (30) tick();
    lit("s6_disabled", tr.size() + tl.size() + td.size() + tu.size(), 0);
    enable = 1'b1;
    batch(32, 0, 4);
    tick();
    lit("s6_enabled", movement, 4'b1000);

    // randomized traffic against the model
    burst = 0; dis_cnt = 0; tx = 0; ty = 0;
    for (int c = 0; c < 4000; c++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 299) == 0) burst = $urandom_range(90, 130);
      if (dis_cnt > 0) begin
        dis_cnt--;
        if (dis_cnt == 0) enable = 1'b1;
      end else if ($urandom_range(0, 149) == 0) begin
        enable = 1'b0;
        dis_cnt = $urandom_range(1, 40);
      end
      if ($urandom_range(0, 5) == 0) begin
        tx = tgt[$urandom_range(0, 15)];
        ty = tgt[$urandom_range(0, 15)];
      end
      sample_valid = (burst == 0) && ($urandom_range(0, 9) < 7);
      sample_x = 8'(clamp8(tx + int'($urandom_range(0, 4)) - 2));
      sample_y = 8'(clamp8(ty + int'($urandom_range(0, 4)) - 2));
      reset_n = (c != 2500);
      tick();
    end
    sample_valid = 1'b0;
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
